// File: rtl/ntru_pack_pkg.sv
// Shared constants and types for the NTRU trit packing/unpacking datapath.
package ntru_pack_pkg;

  localparam int TRITS_PER_BYTE = 5;

  typedef enum logic [1:0] {
    TRIT_0   = 2'b00,
    TRIT_1   = 2'b01,
    TRIT_2   = 2'b10,
    TRIT_ILL = 2'b11
  } trit_e;

  localparam logic [7:0] POW3 [0:4] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

endpackage

// File: rtl/trit_weight_term.sv
// Combinational t * 3^k for one trit at group position k; no multiplier.
module trit_weight_term
  import ntru_pack_pkg::*;
(
  input  logic [1:0] trit,
  input  logic [2:0] k,
  output logic [7:0] term
);

  logic [7:0] w;

  // Select the weight, then form 0, w or 2w from the trit code.
  always_comb begin
    w    = 8'd0;
    term = 8'd0;
    if (k <= 3'd4) begin
      w = POW3[k];
    end else begin
      w = 8'd0;
    end
    case (trit_e'(trit))
      TRIT_1:  term = w;
      TRIT_2:  term = {w[6:0], 1'b0};
      default: term = 8'd0;
    endcase
  end

endmodule

// File: rtl/trit_pack_stream.sv
// Streaming packer: five trits per byte, little-endian base 3, N_TRITS per polynomial.
// Define TRIT_PACK_ERR_EN to build the sticky illegal-trit (2'b11) detector.
module trit_pack_stream
  import ntru_pack_pkg::*;
#(
  parameter int N_TRITS = 701
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_trit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err
);

  localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TRITS - 1);
  localparam logic [2:0] K_LAST = 3'(TRITS_PER_BYTE - 1);

  logic [7:0]       acc_q, acc_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic [7:0] term_s;
  logic [7:0] sum_s;
  logic       last_trit_s;
  logic       completing_s;
  logic       in_hs_s;

  trit_weight_term u_term (
    .trit (in_trit),
    .k    (k_q),
    .term (term_s)
  );

  assign sum_s        = acc_q + term_s;
  assign last_trit_s  = (cnt_q == CNT_LAST);
  assign completing_s = (k_q == K_LAST) || last_trit_s;
  // Only a completing trit needs room in the output register.
  assign in_ready     = !(completing_s && out_valid_q && !out_ready);
  assign in_hs_s      = in_valid && in_ready;

  // Next-state for the accumulator, position/index counters and output register.
  always_comb begin
    acc_d       = acc_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (clr) begin
      acc_d = 8'd0;
      k_d   = 3'd0;
      cnt_d = '0;
    end else if (in_hs_s) begin
      cnt_d = last_trit_s ? '0 : cnt_q + CNT_W'(1);
      if (completing_s) begin
        out_data_d  = sum_s;
        out_valid_d = 1'b1;
        out_last_d  = last_trit_s;
        acc_d       = 8'd0;
        k_d         = 3'd0;
      end else begin
        acc_d = sum_s;
        k_d   = k_q + 3'd1;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= 8'd0;
      k_q         <= 3'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef TRIT_PACK_ERR_EN
  logic err_q, err_d;

  // Sticky flag: survives clr, only rst clears it.
  always_comb begin
    err_d = err_q;
    if (!clr && in_hs_s && (trit_e'(in_trit) == TRIT_ILL)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
